// File: rtl/apb_pid_regs_if.sv
// APB bus bundle between the bridge and the PID register block.
// PCLKEN travels with the bus because it gates every APB phase.
interface apb_pid_regs_if #(
  parameter int ADDRWIDTH = 14
);
  logic                 PCLKEN;
  logic                 PSEL;
  logic                 PENABLE;
  logic [ADDRWIDTH-1:0] PADDR;
  logic                 PWRITE;
  logic [31:0]          PWDATA;
  logic [3:0]           PSTRB;
  logic [2:0]           PPROT;
  logic [31:0]          PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  modport master (
    output PCLKEN, PSEL, PENABLE, PADDR,
    output PWRITE, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PCLKEN, PSEL, PENABLE, PADDR,
    input  PWRITE, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_pid_regs.sv
// APB completer holding PID coefficients, setpoint, control and status.
// Runs on HCLK; APB phases advance only when PCLKEN is high.
module apb_pid_regs #(
  parameter int          ADDRWIDTH = 14,
  parameter logic [31:0] ID_VALUE  = 32'h5049_0001
) (
  input  logic        HCLK,
  input  logic        HRESET,
  apb_pid_regs_if.slave apb,
  output logic [15:0] kp,
  output logic [15:0] ki,
  output logic [15:0] kd,
  output logic [31:0] setpoint,
  output logic        pid_enable,
  output logic        clr_int,
  output logic        coeff_update,
  input  logic        core_busy,
  input  logic        sat_event
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [2:0] OFF_CTRL = 3'd0;
  localparam logic [2:0] OFF_KP   = 3'd1;
  localparam logic [2:0] OFF_KI   = 3'd2;
  localparam logic [2:0] OFF_KD   = 3'd3;
  localparam logic [2:0] OFF_SP   = 3'd4;
  localparam logic [2:0] OFF_STAT = 3'd5;
  localparam logic [2:0] OFF_WAIT = 3'd6;
  localparam logic [2:0] OFF_ID   = 3'd7;

  state_t      state;
  logic [1:0]  wait_cnt;
  logic [1:0]  waitcfg;
  logic        sat;
  logic        ready;
  logic        mapped;
  logic [2:0]  off;
  logic        err;
  logic        done;
  logic        wr;
  logic        sat_clr;
  logic [31:0] rdata;
  logic [31:0] wmask;
  logic [31:0] wd;
  logic        unused_bits;

  assign unused_bits = ^{apb.PPROT[2:1], apb.PADDR[1:0]};

  assign mapped = (apb.PADDR[ADDRWIDTH-1:5] == '0);
  assign off    = apb.PADDR[4:2];
  assign ready  = (state == ACCESS) && (wait_cnt == 2'd0);
  assign wd     = apb.PWDATA;

  assign wmask = {{8{apb.PSTRB[3]}}, {8{apb.PSTRB[2]}},
                  {8{apb.PSTRB[1]}}, {8{apb.PSTRB[0]}}};

  always_comb begin
    err = !mapped;
    if (mapped && apb.PWRITE) begin
      unique case (1'b1)
        (off == OFF_CTRL): err = !apb.PPROT[0];
        (off == OFF_ID):   err = 1'b1;
        default:           err = 1'b0;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    unique case (off)
      OFF_CTRL: rdata = {31'b0, pid_enable};
      OFF_KP:   rdata = {16'b0, kp};
      OFF_KI:   rdata = {16'b0, ki};
      OFF_KD:   rdata = {16'b0, kd};
      OFF_SP:   rdata = setpoint;
      OFF_STAT: rdata = {30'b0, sat, core_busy};
      OFF_WAIT: rdata = {30'b0, waitcfg};
      OFF_ID:   rdata = ID_VALUE;
    endcase
  end

  assign apb.PREADY  = ready;
  assign apb.PSLVERR = ready && err;
  assign apb.PRDATA  =
    (ready && !apb.PWRITE && mapped) ? rdata : '0;

  assign done = apb.PCLKEN && apb.PSEL &&
                apb.PENABLE && ready;
  assign wr   = done && apb.PWRITE && !err;

  // W1C only through byte lane 0, where the sticky bit lives
  assign sat_clr = wr && (off == OFF_STAT) &&
                   apb.PSTRB[0] && wd[1];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state        <= IDLE;
      wait_cnt     <= 2'd0;
      waitcfg      <= 2'd0;
      kp           <= '0;
      ki           <= '0;
      kd           <= '0;
      setpoint     <= '0;
      pid_enable   <= 1'b0;
      sat          <= 1'b0;
      clr_int      <= 1'b0;
      coeff_update <= 1'b0;
    end else begin
      clr_int      <= 1'b0;
      coeff_update <= 1'b0;

      unique case (state)
        IDLE: begin
          if (apb.PCLKEN && apb.PSEL && !apb.PENABLE) begin
            wait_cnt <= waitcfg;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (apb.PCLKEN) begin
            if (!apb.PSEL)
              state <= IDLE;
            else if (wait_cnt != 2'd0)
              wait_cnt <= wait_cnt - 2'd1;
            else if (apb.PENABLE)
              state <= IDLE;
          end
        end
      endcase

      if (wr) begin
        unique case (off)
          OFF_CTRL: begin
            if (apb.PSTRB[0]) pid_enable <= wd[0];
            clr_int <= apb.PSTRB[0] && wd[1];
          end
          OFF_KP: begin
            kp <= (kp & ~wmask[15:0]) | (wd[15:0] & wmask[15:0]);
            coeff_update <= 1'b1;
          end
          OFF_KI: begin
            ki <= (ki & ~wmask[15:0]) | (wd[15:0] & wmask[15:0]);
            coeff_update <= 1'b1;
          end
          OFF_KD: begin
            kd <= (kd & ~wmask[15:0]) | (wd[15:0] & wmask[15:0]);
            coeff_update <= 1'b1;
          end
          OFF_SP: begin
            setpoint <= (setpoint & ~wmask) | (wd & wmask);
            coeff_update <= 1'b1;
          end
          OFF_WAIT: begin
            if (apb.PSTRB[0]) waitcfg <= wd[1:0];
          end
          default: ;
        endcase
      end

      sat <= sat_event || (sat && !sat_clr);
    end
  end

endmodule

// File: doc/apb_pid_regs.md
Name: apb_pid_regs

Overview:
- APB completer (slave) register block for the PID accelerator.
- Sits on the APB side of the AHB-to-APB bridge and decodes PSEL/PENABLE/PADDR/PSTRB/PPROT.
- Holds PID coefficients, setpoint, control and status, with programmable wait states, PSLVERR generation and a coefficient-update strobe to the PID core.
- Runs on the bridge clock HCLK and advances APB phases only on PCLKEN.

Parameters:
ADDRWIDTH, 14, APB address width (bits [1:0] ignored)
ID_VALUE, 32'h5049_0001, read-only value of the ID register

Ports:
HCLK  in  1  clock
HRESET  in  1  synchronous active-high reset
PCLKEN  in  1  APB clock enable; APB phases advance only when 1
PSEL  in  1  APB select
PENABLE  in  1  APB enable (access phase)
PADDR  in  ADDRWIDTH  APB address
PWRITE  in  1  1=write
PWDATA  in  32  write data
PSTRB  in  4  byte-lane write strobes
PPROT  in  3  protection; PPROT[0]=privileged
PRDATA  out  32  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  error response
kp, ki, kd  out  16 each  PID coefficients
setpoint  out  32  PID setpoint
pid_enable  out  1  CTRL[0]
clr_int  out  1  one-cycle pulse, integrator clear
coeff_update  out  1  one-cycle pulse after a successful KP/KI/KD/SETPOINT write
core_busy  in  1  PID core busy, STATUS[0]
sat_event  in  1  single-cycle saturation pulse, sets STATUS[1]

Behaviour:
- Single clock HCLK; reset synchronous, active-high (HRESET). All state is updated on the HCLK rising edge.
- Register map (word offsets; unused bits read 0):
  - 0x00 CTRL: [0] enable RW; [1] clr_int, write-1 pulse, reads 0. Privileged write only.
  - 0x04 KP [15:0]; 0x08 KI [15:0]; 0x0C KD [15:0].
  - 0x10 SETPOINT [31:0].
  - 0x14 STATUS: [0] core_busy RO; [1] sat sticky, write-1-to-clear.
  - 0x18 WAITCFG [1:0]: extra wait states, 0..3.
  - 0x1C ID: RO, ID_VALUE.
  - Any other offset: unmapped.
- Reset values: all registers 0 except ID. PRDATA=0, PREADY=0, PSLVERR=0, clr_int=0, coeff_update=0, FSM=IDLE, wait_cnt=0.
- FSM, states IDLE and ACCESS:
  - IDLE: on PCLKEN & PSEL & ~PENABLE, load wait_cnt<=WAITCFG and go to ACCESS.
  - ACCESS: on PCLKEN with wait_cnt!=0, decrement wait_cnt.
  - ACCESS: on PCLKEN & PSEL & PENABLE & PREADY, complete the transfer and return to IDLE.
  - ACCESS: if PSEL=0 on a PCLKEN cycle, abort to IDLE with no register effect.
- Outputs, combinational from registered state:
  - PREADY = (state==ACCESS) & (wait_cnt==0).
  - PRDATA = decoded read data when PREADY & ~PWRITE & mapped, else 0.
  - PSLVERR = PREADY & error, else 0.
- Latency: with WAITCFG=N, PREADY rises on the (N+1)th PCLKEN access-phase cycle. WAITCFG changes take effect from the next transfer.
- Error cases (PSLVERR=1, no register change):
  - unmapped address, read or write;
  - write to CTRL with PPROT[0]=0;
  - write to ID.
- Writes:
  - Committed only in the completing cycle; per-byte masked by PSTRB.
  - PSTRB=0: OKAY, no change.
  - Bytes beyond a register's width are ignored.
- Pulses:
  - clr_int pulses 1 cycle when a committed CTRL write has PWDATA[1]=1 and PSTRB[0]=1.
  - coeff_update pulses 1 cycle after a committed write to 0x04–0x10, including PSTRB=0 writes.
- STATUS[1]: set by sat_event, cleared by a W1C write. Set wins over a same-cycle clear.
- Reset mid-transfer: FSM returns to IDLE and PREADY=0. The pending write is dropped.

Test Plan:
- WAITCFG=0, privileged write KP=0x1234, PSTRB=0xF -> PREADY=1 on the first access cycle, PSLVERR=0, kp=0x1234, coeff_update one pulse next cycle; read 0x04 returns 0x0000_1234.
- WAITCFG=2, PCLKEN toggling 1/0 -> PREADY low for exactly 2 PCLKEN access cycles, and held across PCLKEN=0 cycles.
- Write SETPOINT=0xAABBCCDD with PSTRB=4'b0101 onto 0 -> setpoint=0x00BB00DD.
- Read 0x20 -> PSLVERR=1, PRDATA=0. Write CTRL=0x3 with PPROT=0 -> PSLVERR=1, pid_enable=0, no clr_int.
- sat_event in the same cycle as a W1C write of 0x2 to STATUS -> STATUS[1] stays 1; a later W1C without sat_event -> 0.
- HRESET asserted during a 3-wait write to KD=0x55 -> kd=0, PREADY=0, FSM IDLE; the next transfer completes normally.
